inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction fetch queue between the PC/instruction-ROM fetch stage and the decode (ID) stage.
//  Each cycle the fetch stage presents {pc, inst}; valid pairs are captured into a small circular FIFO.
//  Decode drains the FIFO with a valid/ready handshake.
//  When the FIFO fills, the queue asserts a stall back to the PC generator. A flush (branch/exception) discards all entries.
// PARAMETERS
//  DEPTH       4    number of {pc,inst} entries; power of two, >= 2
//  ADDR_W      32   PC width (matches InstAddrBus)
//  INST_W      32   instruction width (matches InstBus)
// PORTS
//  clk          in   1        system clock, all state updates on posedge
//  rst          in   1        synchronous reset, active-high
//  if_ce_i      in   1        fetch valid (instruction memory chip-enable from PC stage)
//  if_pc_i      in   ADDR_W   address of the instruction being fetched
//  if_inst_i    in   INST_W   instruction word read from instruction ROM this cycle
//  if_stall_o   out  1        1 = queue full; PC stage must hold pc and not advance
//  flush_i      in   1        discard all queued entries and the current fetch
//  id_valid_o   out  1        head entry available to decode
//  id_pc_o      out  ADDR_W   PC of head entry (0 when empty)
//  id_inst_o    out  INST_W   instruction of head entry (0 = NOP when empty)
//  id_ready_i   in   1        decode accepts head entry this cycle
//  count_o      out  $clog2(DEPTH+1)  number of occupied entries
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - count, wr_ptr, rd_ptr <= 0.
//   - Resulting outputs: id_valid_o=0, id_pc_o=0, id_inst_o=0, if_stall_o=0, count_o=0.
//   - Storage array is not reset.
//   - rst overrides flush_i and all handshakes; reset mid-stream drops every entry.
//  Derived signals (combinational from registered state only)
//   - full  = (count==DEPTH); empty = (count==0).
//   - if_stall_o = full. It does NOT depend on id_ready_i, so there is no comb path from ID to the PC.
//   - id_valid_o = !empty.
//   - id_pc_o / id_inst_o = mem[rd_ptr] when !empty, else 0.
//  Push / pop
//   - push = if_ce_i && !full && !flush_i. Writes {if_pc_i, if_inst_i} to mem[wr_ptr]; wr_ptr+1.
//   - pop  = id_valid_o && id_ready_i && !flush_i. rd_ptr+1.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
//   - count_next = count + push - pop.
//   - Simultaneous push & pop (not full, not empty): count unchanged, both pointers advance.
//   - When full, push is blocked even if a pop occurs the same cycle; stall releases the next cycle.
//   - Push while empty: data is visible on id_* the cycle after the capture edge (1-cycle latency).
//   - A push into an empty queue never bypasses the FIFO to id_*.
//   - Pop when empty: impossible by construction (id_valid_o=0), so id_ready_i is ignored.
//   - if_ce_i=0 (PC stage in reset/disabled): no push, regardless of if_pc_i/if_inst_i.
//  Flush (flush_i=1 at posedge, rst=0)
//   - count, wr_ptr, rd_ptr <= 0.
//   - The same-cycle fetch is dropped and the same-cycle pop does not count as a transfer.
//   - The next cycle: id_valid_o=0 and if_stall_o=0.
//   - Flush on an empty queue is harmless.
//  No state machine beyond the FIFO; ordering is strictly first-in/first-out.
// TESTING
//  1. Reset: rst=1 for 2 cycles with if_ce_i=1 -> id_valid_o=0, id_pc_o=0, id_inst_o=0,
//     if_stall_o=0, count_o=0.
//  2. Streaming: push pc=0x0,0x4,0x8 (inst 0x34011100,..) with id_ready_i=1
//     -> each pair appears on id_* one cycle after capture, in order, and count_o stays <=1.
//  3. Fill: id_ready_i=0, push 4 entries pc=0x0..0xC -> count_o=4 and if_stall_o=1.
//     A 5th fetch pc=0x10 is not stored; raising id_ready_i pops 0x0, 0x4, 0x8, 0xC in order.
//  4. Full + pop same cycle: count=4, id_ready_i=1, if_ce_i=1 -> count_o=3 and if_stall_o=0 next
//     cycle; the blocked fetch is accepted the cycle after.
//  5. Wrap: run 10 push/pop pairs through DEPTH=4 -> pointers wrap and the pc sequence 0x0..0x24
//     emerges unbroken.
//  6. Flush: count=3, assert flush_i with if_ce_i=1 and id_ready_i=1 -> next cycle count_o=0,
//     id_valid_o=0, id_inst_o=0; the following fetch pc=0x100 is the next entry delivered.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode bundle: fetch pair, stall/flush, decode handshake.
// master = fetch/decode side, slave = the queue.
interface inst_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              if_ce_i;
    logic [ADDR_W-1:0] if_pc_i;
    logic [INST_W-1:0] if_inst_i;
    logic              if_stall_o;
    logic              flush_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_ready_i;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output if_ce_i, if_pc_i, if_inst_i, flush_i, id_ready_i,
        input  if_stall_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );

    modport slave (
        input  if_ce_i, if_pc_i, if_inst_i, flush_i, id_ready_i,
        output if_stall_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular {pc, inst} FIFO between fetch and decode.
// Stall is driven from the registered count only, never from id_ready.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full, empty, push, pop;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        push  = bus.if_ce_i && !full && !bus.flush_i;
        pop   = !empty && bus.id_ready_i && !bus.flush_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; the count alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem_q[wr_ptr_q]   <= bus.if_pc_i;
            inst_mem_q[wr_ptr_q] <= bus.if_inst_i;
        end
    end

    always_comb begin
        bus.if_stall_o = full;
        bus.id_valid_o = !empty;
        bus.count_o    = count_q;
        bus.id_pc_o    = '0;
        bus.id_inst_o  = '0;
        if (!empty) begin
            bus.id_pc_o   = pc_mem_q[rd_ptr_q];
            bus.id_inst_o = inst_mem_q[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every
// cycle, plus hand-computed literal expectations on the directed scenarios.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mpc   [$];
    logic [31:0] minst [$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h3401_1100 + pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int n;
        n = mpc.size();
        chk("count", 32'(bus.count_o), 32'(n));
        chk("valid", 32'(bus.id_valid_o), 32'(n > 0));
        chk("stall", 32'(bus.if_stall_o), 32'(n == DEPTH));
        chk("id_pc", bus.id_pc_o, (n > 0) ? mpc[0] : 32'h0);
        chk("id_inst", bus.id_inst_o, (n > 0) ? minst[0] : 32'h0);
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic cyc(input logic ce, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic r);
        logic full, do_pop, do_push;
        bus.if_ce_i    = ce;
        bus.if_pc_i    = pc;
        bus.if_inst_i  = inst_of(pc);
        bus.id_ready_i = rdy;
        bus.flush_i    = fl;
        rst            = r;
        @(posedge clk);
        if (r || fl) begin
            mpc.delete();
            minst.delete();
        end else begin
            full    = (mpc.size() == DEPTH);
            do_pop  = (mpc.size() > 0) && rdy;
            do_push = ce && !full;
            if (do_pop) begin
                void'(mpc.pop_front());
                void'(minst.pop_front());
            end
            if (do_push) begin
                mpc.push_back(pc);
                minst.push_back(inst_of(pc));
            end
        end
        #1;
        compare();
    endtask

    initial begin
        bus.if_ce_i    = 1'b0;
        bus.if_pc_i    = '0;
        bus.if_inst_i  = '0;
        bus.id_ready_i = 1'b0;
        bus.flush_i    = 1'b0;

        // Reset with fetch enabled
        cyc(1, 32'h0, 0, 0, 1);
        cyc(1, 32'h4, 1, 0, 1);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
        chk("rst_pc", bus.id_pc_o, 32'd0);

        // Streaming with decode always ready
        cyc(1, 32'h0, 1, 0, 0);
        chk("str_pc0", bus.id_pc_o, 32'h0);
        chk("str_inst0", bus.id_inst_o, 32'h3401_1100);
        cyc(1, 32'h4, 1, 0, 0);
        chk("str_pc1", bus.id_pc_o, 32'h4);
        chk("str_cnt1", 32'(bus.count_o), 32'd1);
        cyc(1, 32'h8, 1, 0, 0);
        chk("str_pc2", bus.id_pc_o, 32'h8);
        cyc(0, 32'hC, 1, 0, 0);
        chk("str_empty", 32'(bus.id_valid_o), 32'd0);

        // Fill, blocked 5th fetch, then drain
        for (int i = 0; i < 4; i++) cyc(1, 32'(4 * i), 0, 0, 0);
        chk("fill_cnt", 32'(bus.count_o), 32'd4);
        chk("fill_stall", 32'(bus.if_stall_o), 32'd1);
        cyc(1, 32'h10, 0, 0, 0);
        chk("fill_blk_cnt", 32'(bus.count_o), 32'd4);
        cyc(0, 32'h0, 1, 0, 0);
        chk("drain_pc1", bus.id_pc_o, 32'h4);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0, 0);
        chk("drain_empty", 32'(bus.count_o), 32'd0);

        // Full with same-cycle pop: push blocked, accepted next cycle
        for (int i = 0; i < 4; i++) cyc(1, 32'h20 + 32'(4 * i), 0, 0, 0);
        cyc(1, 32'h30, 1, 0, 0);
        chk("fp_cnt", 32'(bus.count_o), 32'd3);
        chk("fp_stall", 32'(bus.if_stall_o), 32'd0);
        cyc(1, 32'h30, 0, 0, 0);
        chk("fp_cnt2", 32'(bus.count_o), 32'd4);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0, 0);
        chk("fp_tail", bus.id_pc_o, 32'h30);
        cyc(0, 32'h0, 1, 0, 0);

        // Pointer wrap: ten back-to-back transfers
        for (int i = 0; i < 10; i++) cyc(1, 32'(4 * i), 1, 0, 0);
        chk("wrap_pc", bus.id_pc_o, 32'h24);
        chk("wrap_cnt", 32'(bus.count_o), 32'd1);
        cyc(0, 32'h0, 1, 0, 0);

        // Flush with fetch and pop active
        for (int i = 0; i < 3; i++) cyc(1, 32'h40 + 32'(4 * i), 0, 0, 0);
        cyc(1, 32'h4C, 1, 1, 0);
        chk("fl_cnt", 32'(bus.count_o), 32'd0);
        chk("fl_valid", 32'(bus.id_valid_o), 32'd0);
        chk("fl_inst", bus.id_inst_o, 32'd0);
        cyc(1, 32'h100, 0, 0, 0);
        chk("fl_next", bus.id_pc_o, 32'h100);
        cyc(0, 32'h0, 1, 1, 0);
        cyc(0, 32'h0, 1, 1, 0);
        chk("fl_empty", 32'(bus.count_o), 32'd0);

        // Reset mid-stream overrides flush and handshakes
        cyc(1, 32'h200, 0, 0, 0);
        cyc(1, 32'h204, 0, 0, 0);
        cyc(1, 32'h208, 1, 1, 1);
        chk("rst_mid", 32'(bus.count_o), 32'd0);

        // Mixed traffic
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
